// File: rtl/tm1638_spi_arbiter.sv
// Two-requester frame arbiter feeding the TM1638 SPI command FIFO.
// Frames are granted round-robin and never interrupted; read data is routed back to its owner.
module tm1638_spi_arbiter #(
    parameter int HOLDOFF_CYCLES = 2,
    parameter int RD_OUTSTANDING = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Req0_Valid,
    input  logic [7:0]  i_Req0_Data,
    input  logic        i_Req0_Last,
    input  logic        i_Req0_Read,
    output logic        o_Req0_Ready,
    input  logic        i_Req1_Valid,
    input  logic [7:0]  i_Req1_Data,
    input  logic        i_Req1_Last,
    input  logic        i_Req1_Read,
    output logic        o_Req1_Ready,
    output logic [9:0]  o_FIFO_Data,
    output logic        o_FIFO_Wr,
    input  logic        i_FIFO_Full,
    input  logic [31:0] i_Rd_Data,
    input  logic        i_Rd_Valid,
    output logic [31:0] o_Resp0_Data,
    output logic        o_Resp0_Valid,
    output logic [31:0] o_Resp1_Data,
    output logic        o_Resp1_Valid,
    output logic [1:0]  o_Diag_State,
    output logic        o_Diag_Owner,
    output logic        o_Diag_Rd_Orphan
);

    localparam int HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_END = HW'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);
    localparam logic [1:0] Q_LAST = 2'(RD_OUTSTANDING - 1);
    localparam logic [2:0] Q_DEPTH = 3'(RD_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic            owner;
    logic            rr_last;
    logic            first_word;
    logic            frame_rd;
    logic [HW-1:0]   hold_cnt;
    logic [3:0]      q_mem;
    logic [1:0]      q_rd;
    logic [1:0]      q_wr;
    logic [2:0]      q_cnt;
    logic            orphan;

    logic            q_full;
    logic            q_empty;
    logic            elig0;
    logic            elig1;
    logic            grant;
    logic            own_valid;
    logic            own_last;
    logic            own_read;
    logic [7:0]      own_data;
    logic            xfer_ok;
    logic            accept;
    logic            word_rd;
    logic            push;
    logic            pop;
    logic            head;

    function automatic logic [1:0] q_next(input logic [1:0] p);
        return (p == Q_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign q_full  = (q_cnt == Q_DEPTH);
    assign q_empty = (q_cnt == 3'd0);
    assign head    = q_mem[q_rd];

    // A read frame is only eligible while there is room to remember who owns its response.
    assign elig0 = i_Req0_Valid & (~i_Req0_Read | ~q_full);
    assign elig1 = i_Req1_Valid & (~i_Req1_Read | ~q_full);
    assign grant = (elig0 & elig1) ? ~rr_last : elig1;

    assign own_valid = owner ? i_Req1_Valid : i_Req0_Valid;
    assign own_last  = owner ? i_Req1_Last  : i_Req0_Last;
    assign own_read  = owner ? i_Req1_Read  : i_Req0_Read;
    assign own_data  = owner ? i_Req1_Data  : i_Req0_Data;

    assign xfer_ok      = (state == XFER) & ~i_FIFO_Full;
    assign o_Req0_Ready = xfer_ok & ~owner;
    assign o_Req1_Ready = xfer_ok & owner;
    assign accept       = xfer_ok & own_valid;

    // The first word carries the read flag live; later words reuse the latched copy.
    assign word_rd     = first_word ? own_read : frame_rd;
    assign o_FIFO_Wr   = accept;
    assign o_FIFO_Data = accept ? {word_rd, own_last, own_data} : 10'd0;

    assign push = accept & first_word & own_read;
    assign pop  = i_Rd_Valid & ~q_empty;

    assign o_Diag_State     = state;
    assign o_Diag_Owner     = owner;
    assign o_Diag_Rd_Orphan = orphan;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= IDLE;
            owner         <= 1'b0;
            rr_last       <= 1'b1;
            first_word    <= 1'b0;
            frame_rd      <= 1'b0;
            hold_cnt      <= '0;
            q_mem         <= 4'd0;
            q_rd          <= 2'd0;
            q_wr          <= 2'd0;
            q_cnt         <= 3'd0;
            orphan        <= 1'b0;
            o_Resp0_Valid <= 1'b0;
            o_Resp1_Valid <= 1'b0;
            o_Resp0_Data  <= 32'd0;
            o_Resp1_Data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        state      <= XFER;
                        owner      <= grant;
                        rr_last    <= grant;
                        first_word <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept) begin
                        first_word <= 1'b0;
                        if (first_word) begin
                            frame_rd <= own_read;
                        end
                        if (own_last) begin
                            if (HOLDOFF_CYCLES == 0) begin
                                state <= IDLE;
                            end else begin
                                state    <= HOLD;
                                hold_cnt <= '0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_END) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                q_mem[q_wr] <= owner;
                q_wr        <= q_next(q_wr);
            end
            if (pop) begin
                q_rd <= q_next(q_rd);
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 3'd1;
                2'b01:   q_cnt <= q_cnt - 3'd1;
                default: q_cnt <= q_cnt;
            endcase

            o_Resp0_Valid <= pop & ~head;
            o_Resp1_Valid <= pop & head;
            if (pop & ~head) begin
                o_Resp0_Data <= i_Rd_Data;
            end
            if (pop & head) begin
                o_Resp1_Data <= i_Rd_Data;
            end
            if (i_Rd_Valid & q_empty) begin
                orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tm1638_spi_arbiter.sv
// Directed bench for tm1638_spi_arbiter: requester word queues drive the DUT, FIFO writes are logged
// and compared against hand-computed {read,last,byte} sequences.
module tb_tm1638_spi_arbiter;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_Req0_Valid, i_Req0_Last, i_Req0_Read, o_Req0_Ready;
    logic [7:0]  i_Req0_Data;
    logic        i_Req1_Valid, i_Req1_Last, i_Req1_Read, o_Req1_Ready;
    logic [7:0]  i_Req1_Data;
    logic [9:0]  o_FIFO_Data;
    logic        o_FIFO_Wr;
    logic        i_FIFO_Full;
    logic [31:0] i_Rd_Data;
    logic        i_Rd_Valid;
    logic [31:0] o_Resp0_Data, o_Resp1_Data;
    logic        o_Resp0_Valid, o_Resp1_Valid;
    logic [1:0]  o_Diag_State;
    logic        o_Diag_Owner;
    logic        o_Diag_Rd_Orphan;

    int total = 0;
    int bad = 0;

    // Requester words are {read, last, byte}; the log holds every FIFO word written.
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] wlog[$];
    logic       acc0, acc1;

    tm1638_spi_arbiter #(.HOLDOFF_CYCLES(2), .RD_OUTSTANDING(2)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Req0_Valid(i_Req0_Valid), .i_Req0_Data(i_Req0_Data), .i_Req0_Last(i_Req0_Last),
        .i_Req0_Read(i_Req0_Read), .o_Req0_Ready(o_Req0_Ready),
        .i_Req1_Valid(i_Req1_Valid), .i_Req1_Data(i_Req1_Data), .i_Req1_Last(i_Req1_Last),
        .i_Req1_Read(i_Req1_Read), .o_Req1_Ready(o_Req1_Ready),
        .o_FIFO_Data(o_FIFO_Data), .o_FIFO_Wr(o_FIFO_Wr), .i_FIFO_Full(i_FIFO_Full),
        .i_Rd_Data(i_Rd_Data), .i_Rd_Valid(i_Rd_Valid),
        .o_Resp0_Data(o_Resp0_Data), .o_Resp0_Valid(o_Resp0_Valid),
        .o_Resp1_Data(o_Resp1_Data), .o_Resp1_Valid(o_Resp1_Valid),
        .o_Diag_State(o_Diag_State), .o_Diag_Owner(o_Diag_Owner),
        .o_Diag_Rd_Orphan(o_Diag_Rd_Orphan)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveReqs();
        i_Req0_Valid = (q0.size() != 0);
        {i_Req0_Read, i_Req0_Last, i_Req0_Data} = (q0.size() != 0) ? q0[0] : 10'd0;
        i_Req1_Valid = (q1.size() != 0);
        {i_Req1_Read, i_Req1_Last, i_Req1_Data} = (q1.size() != 0) ? q1[0] : 10'd0;
    endtask

    // One clock: sample mid-cycle, cross the edge, retire accepted words, present the next ones.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            #4;
            acc0 = i_Req0_Valid & o_Req0_Ready;
            acc1 = i_Req1_Valid & o_Req1_Ready;
            if (o_FIFO_Wr) wlog.push_back(o_FIFO_Data);
            @(posedge i_Clk);
            #1;
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
            driveReqs();
            #1;
        end
    endtask

    task automatic applyReset();
        i_Rst = 1'b1;
        q0.delete();
        q1.delete();
        driveReqs();
        applyStimulus(2);
        i_Rst = 1'b0;
        wlog.delete();
    endtask

    task automatic pushFrame(input int who, input logic rd, input logic [7:0] first, input int len);
        for (int k = 0; k < len; k++) begin
            if (who == 0) q0.push_back({rd, (k == len - 1), first + 8'(k)});
            else          q1.push_back({rd, (k == len - 1), first + 8'(k)});
        end
        driveReqs();
        #1;
    endtask

    logic [9:0] expContention[12];

    initial begin
        i_Rst = 1'b1;
        i_FIFO_Full = 1'b0;
        i_Rd_Valid = 1'b0;
        i_Rd_Data = 32'd0;
        q0.delete();
        q1.delete();
        driveReqs();
        applyReset();

        checkOutput("rst_state", 32'(o_Diag_State), 32'd0);
        checkOutput("rst_owner", 32'(o_Diag_Owner), 32'd0);
        checkOutput("rst_ready", 32'({o_Req0_Ready, o_Req1_Ready}), 32'd0);
        checkOutput("rst_fifo", 32'({o_FIFO_Wr, o_FIFO_Data}), 32'd0);
        checkOutput("rst_resp", 32'({o_Resp0_Valid, o_Resp1_Valid}), 32'd0);
        checkOutput("rst_respdata", o_Resp0_Data | o_Resp1_Data, 32'd0);
        checkOutput("rst_orphan", 32'(o_Diag_Rd_Orphan), 32'd0);

        // Single write frame with a two-cycle holdoff.
        pushFrame(0, 1'b0, 8'h40, 1);
        checkOutput("w1_idle_ready", 32'(o_Req0_Ready), 32'd0);
        applyStimulus(1);
        checkOutput("w1_xfer", 32'(o_Diag_State), 32'd1);
        checkOutput("w1_ready", 32'(o_Req0_Ready), 32'd1);
        checkOutput("w1_wr", 32'(o_FIFO_Wr), 32'd1);
        checkOutput("w1_data", 32'(o_FIFO_Data), 32'h140);
        applyStimulus(1);
        checkOutput("w1_hold1", 32'(o_Diag_State), 32'd2);
        checkOutput("w1_hold_wr", 32'(o_FIFO_Wr), 32'd0);
        checkOutput("w1_hold_ready", 32'(o_Req0_Ready), 32'd0);
        applyStimulus(1);
        checkOutput("w1_hold2", 32'(o_Diag_State), 32'd2);
        applyStimulus(1);
        checkOutput("w1_back_idle", 32'(o_Diag_State), 32'd0);
        checkOutput("w1_nwrites", wlog.size(), 32'd1);

        // Contention from reset, repeated: Req0, Req1, Req0, Req1.
        applyReset();
        expContention = '{10'h001, 10'h002, 10'h103, 10'h011, 10'h012, 10'h113,
                          10'h001, 10'h002, 10'h103, 10'h011, 10'h012, 10'h113};
        pushFrame(0, 1'b0, 8'h01, 3);
        pushFrame(1, 1'b0, 8'h11, 3);
        applyStimulus(20);
        pushFrame(0, 1'b0, 8'h01, 3);
        pushFrame(1, 1'b0, 8'h11, 3);
        applyStimulus(20);
        checkOutput("rr_nwrites", wlog.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("rr_word%0d", i), 32'(wlog[i]), 32'(expContention[i]));
        end

        // Backpressure mid-frame on Req1 while Req0 waits.
        applyReset();
        pushFrame(1, 1'b0, 8'h21, 4);
        applyStimulus(3);
        pushFrame(0, 1'b0, 8'h31, 1);
        i_FIFO_Full = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_ready1_%0d", i), 32'(o_Req1_Ready), 32'd0);
            checkOutput($sformatf("bp_ready0_%0d", i), 32'(o_Req0_Ready), 32'd0);
            checkOutput($sformatf("bp_wr_%0d", i), 32'(o_FIFO_Wr), 32'd0);
            applyStimulus(1);
        end
        i_FIFO_Full = 1'b0;
        applyStimulus(15);
        checkOutput("bp_nwrites", wlog.size(), 32'd5);
        checkOutput("bp_w0", 32'(wlog[0]), 32'h021);
        checkOutput("bp_w1", 32'(wlog[1]), 32'h022);
        checkOutput("bp_w2", 32'(wlog[2]), 32'h023);
        checkOutput("bp_w3", 32'(wlog[3]), 32'h124);
        checkOutput("bp_w4", 32'(wlog[4]), 32'h131);

        // Read routing with a full owner queue.
        applyReset();
        pushFrame(1, 1'b1, 8'h50, 1);
        applyStimulus(5);
        pushFrame(0, 1'b1, 8'h60, 1);
        applyStimulus(5);
        pushFrame(1, 1'b1, 8'h70, 1);
        applyStimulus(6);
        checkOutput("rd_nwrites_full", wlog.size(), 32'd2);
        checkOutput("rd_w0", 32'(wlog[0]), 32'h350);
        checkOutput("rd_w1", 32'(wlog[1]), 32'h360);
        checkOutput("rd_blocked_state", 32'(o_Diag_State), 32'd0);
        i_Rd_Data = 32'hDEADBEEF;
        i_Rd_Valid = 1'b1;
        applyStimulus(1);
        i_Rd_Data = 32'h12345678;
        #1;
        checkOutput("rd_resp1_valid", 32'(o_Resp1_Valid), 32'd1);
        checkOutput("rd_resp1_data", o_Resp1_Data, 32'hDEADBEEF);
        checkOutput("rd_resp0_quiet", 32'(o_Resp0_Valid), 32'd0);
        applyStimulus(1);
        i_Rd_Valid = 1'b0;
        #1;
        checkOutput("rd_resp0_valid", 32'(o_Resp0_Valid), 32'd1);
        checkOutput("rd_resp0_data", o_Resp0_Data, 32'h12345678);
        checkOutput("rd_resp1_strobe", 32'(o_Resp1_Valid), 32'd0);
        applyStimulus(1);
        checkOutput("rd_resp_idle", 32'({o_Resp0_Valid, o_Resp1_Valid}), 32'd0);
        applyStimulus(8);
        checkOutput("rd_nwrites_after", wlog.size(), 32'd3);
        checkOutput("rd_w2", 32'(wlog[2]), 32'h370);

        // Orphan read data.
        applyReset();
        i_Rd_Data = 32'h0000CAFE;
        i_Rd_Valid = 1'b1;
        applyStimulus(1);
        i_Rd_Valid = 1'b0;
        #1;
        checkOutput("orph_resp", 32'({o_Resp0_Valid, o_Resp1_Valid}), 32'd0);
        checkOutput("orph_flag", 32'(o_Diag_Rd_Orphan), 32'd1);
        applyStimulus(3);
        checkOutput("orph_sticky", 32'(o_Diag_Rd_Orphan), 32'd1);
        applyReset();
        checkOutput("orph_cleared", 32'(o_Diag_Rd_Orphan), 32'd0);

        // Reset in the middle of a Req0 frame restores Req0 priority.
        applyReset();
        pushFrame(0, 1'b0, 8'h81, 5);
        applyStimulus(3);
        checkOutput("mid_nwrites", wlog.size(), 32'd2);
        i_Rst = 1'b1;
        q0.delete();
        q1.delete();
        driveReqs();
        applyStimulus(1);
        i_Rst = 1'b0;
        applyStimulus(3);
        checkOutput("mid_state", 32'(o_Diag_State), 32'd0);
        checkOutput("mid_wr", 32'(o_FIFO_Wr), 32'd0);
        checkOutput("mid_nowrites", wlog.size(), 32'd2);
        pushFrame(0, 1'b0, 8'hA0, 1);
        pushFrame(1, 1'b0, 8'hB0, 1);
        applyStimulus(12);
        checkOutput("mid_after_n", wlog.size(), 32'd4);
        checkOutput("mid_first", 32'(wlog[2]), 32'h1A0);
        checkOutput("mid_second", 32'(wlog[3]), 32'h1B0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tm1638_spi_arbiter.md
TM1638_SPI_ARBITER -- requirements
Module: tm1638_spi_arbiter

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 2: minimum idle cycles between frames, for the STB-high gap; 0 is legal.
REQ-002 Parameter RD_OUTSTANDING, default 2: depth of the read-owner queue, range 1..4.
REQ-003 i_Clk  in  1  single clock; all logic on its rising edge.
REQ-004 i_Rst  in  1  synchronous, active-high reset.
REQ-005 i_ReqN_Valid  in  1  (N=0,1) requester N presents a frame word.
REQ-006 i_ReqN_Data  in  8  (N=0,1) frame byte.
REQ-007 i_ReqN_Last  in  1  (N=0,1) word is the last of the frame, where STB rises after it.
REQ-008 i_ReqN_Read  in  1  (N=0,1) frame expects a 32-bit key-scan read; held constant for the whole frame.
REQ-009 o_ReqN_Ready  out  1  (N=0,1) word accepted when Valid and Ready are both high.
REQ-010 o_FIFO_Data  out  10  {read flag, last, byte} written to the SPI command FIFO.
REQ-011 o_FIFO_Wr  out  1  FIFO write strobe.
REQ-012 i_FIFO_Full  in  1  FIFO full.
REQ-013 i_Rd_Data  in  32  read data returned by the SPI engine.
REQ-014 i_Rd_Valid  in  1  one-cycle strobe with i_Rd_Data.
REQ-015 o_RespN_Data  out  32  (N=0,1) routed read data.
REQ-016 o_RespN_Valid  out  1  (N=0,1) one-cycle response strobe.
REQ-017 o_Diag_State  out  2  IDLE=0, XFER=1, HOLD=2.
REQ-018 o_Diag_Owner  out  1  current or last grant owner.
REQ-019 o_Diag_Rd_Orphan  out  1  sticky: read data arrived with the owner queue empty.

Function
REQ-020 FSM states:
- IDLE -> XFER when an eligible requester has Valid high.
- XFER -> HOLD when the owner's Last word is accepted.
- HOLD -> IDLE after HOLDOFF_CYCLES cycles; with HOLDOFF_CYCLES=0, XFER goes directly to IDLE.
REQ-021 Requester N is eligible when i_ReqN_Valid=1 and either (i_ReqN_Read=0) or (the read queue is not full).
REQ-022 Round-robin arbitration:
- With both requesters eligible in IDLE, grant the one not granted last.
- The last-grant pointer resets so that Req0 wins first.
- The pointer updates on grant.
REQ-023 Grant latency is one cycle: Valid is sampled in IDLE and o_ReqN_Ready may assert on the next cycle.
REQ-024 o_ReqN_Ready = (state==XFER) & (owner==N) & !i_FIFO_Full; it is always 0 for the non-owner.
REQ-025 o_FIFO_Wr = owner Valid & owner Ready, combinational in the acceptance cycle; o_FIFO_Data = {frame read flag, owner Last, owner Data}.
REQ-026 The frame read flag is sampled from i_ReqN_Read on the first accepted word and applied to every word of that frame.
REQ-027 The owner id is pushed into the read queue on the first accepted word of a read frame.
REQ-028 Frames are never interrupted. The owner keeps the grant until its Last word is accepted, regardless of the other requester or of Valid gaps.
REQ-029 Read responses:
- i_Rd_Valid pops the queue head.
- o_RespN_Data/Valid are registered, one cycle after i_Rd_Valid, to the popped owner.
- The other response Valid stays 0.
REQ-030 i_Rd_Valid with the queue empty: the data is dropped, no Resp strobe is issued, and o_Diag_Rd_Orphan is set until reset.
REQ-031 A push and a pop in the same cycle are both performed; the occupancy is unchanged and order is preserved.
REQ-032 When the read queue is full, read frames are not granted; write frames still are.
REQ-033 i_FIFO_Full stalls acceptance in any XFER cycle with no word loss; the grant is held through the stall.
REQ-034 The HOLD counter counts HOLDOFF_CYCLES cycles. No Ready is asserted in HOLD, even for the same owner.

Reset
REQ-035 While i_Rst=1 at a clock edge, the block resets to:
- state=IDLE, owner=0, rr pointer set so that Req0 wins first;
- HOLD counter=0;
- read queue empty; o_Diag_Rd_Orphan=0;
- o_ReqN_Ready=0, o_FIFO_Wr=0, o_FIFO_Data=0;
- o_RespN_Valid=0, o_RespN_Data=0.
REQ-036 Reset mid-frame or mid-HOLD aborts immediately. No further FIFO writes for that frame, and outstanding queue entries are discarded.

Verification
REQ-037 Single write frame: Req0 sends 0x40 (Last=1), HOLDOFF_CYCLES=2, FIFO not full.
- Ready is asserted 1 cycle after Valid.
- o_FIFO_Data=0x140, o_FIFO_Wr=1 for one cycle.
- HOLD lasts 2 cycles, then IDLE.
REQ-038 Contention: Req0 and Req1 both hold valid 3-byte write frames from reset.
- Req0's frame completes fully, then HOLD, then Req1's frame.
- Repeating the test yields the order Req0, Req1, Req0, Req1.
REQ-039 Backpressure: i_FIFO_Full=1 for 5 cycles in the middle of Req1's 4-byte frame.
- Ready is 0 during the stall.
- Exactly 4 FIFO writes occur, in order, and Req0 is not granted mid-frame.
REQ-040 Read routing with queue full: RD_OUTSTANDING=2.
- Req1 issues a read frame, then Req0 issues a read frame; a third read request from Req1 is not granted.
- i_Rd_Valid with 0xDEADBEEF then 0x12345678 -> o_Resp1 gets 0xDEADBEEF, then o_Resp0 gets 0x12345678, each 1 cycle after its i_Rd_Valid.
- The third Req1 read frame is granted afterwards.
REQ-041 Orphan: i_Rd_Valid with the queue empty -> no Resp strobe; o_Diag_Rd_Orphan=1 until reset.
REQ-042 Reset mid-frame: i_Rst asserted after 2 of 5 bytes -> o_FIFO_Wr=0 thereafter, state=IDLE, and Req0 wins the next contention.
